// File: rtl/tri_out_monitor.sv
// ---------------------------------------------------------------------------
// tri_out_monitor
//   Watches the three 1-bit results c1/c2/c3 of tri_assignment over a fixed
//   window. It counts the cycles in which each result is high and the cycles
//   in which they disagree. It reports with a one-cycle done pulse and a
//   sticky err flag.
//
//   Ports
//     clk, rst          rising-edge clock, synchronous active-high reset
//     start             begin a window (only looked at in IDLE)
//     c1, c2, c3        observed results; registered before any accounting
//     busy              high while the window runs
//     done              one-cycle pulse, results valid
//     ones_c1..ones_c3  per-result high-cycle counts (saturating, CNT_W bits)
//     mismatch_cnt      cycles where c1,c2,c3 are not all equal (saturating)
//     err               sticky mismatch flag; cleared only by rst
//
//   Build option
//     TRI_MON_EARLY_STOP_EN : the first mismatching RUN sample ends the window
//                             (DONE on the next cycle). Undefined = full window.
// ---------------------------------------------------------------------------

// Saturating counter lane: clears on clr, otherwise adds inc while en.
module tri_out_monitor_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst)                         cnt <= '0;
    else if (clr)                    cnt <= '0;
    else if (en && inc && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule

module tri_out_monitor #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             c1,
  input  logic             c2,
  input  logic             c3,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ones_c1,
  output logic [CNT_W-1:0] ones_c2,
  output logic [CNT_W-1:0] ones_c3,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             err
);
  localparam int WC_W     = $clog2(WIN_LEN + 1);
  localparam int NUM_LANES = 4;   // ones_c1, ones_c2, ones_c3, mismatch

`ifdef TRI_MON_EARLY_STOP_EN
  localparam bit EARLY_STOP = 1'b1;
`else
  localparam bit EARLY_STOP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                              state, state_nxt;
  logic   [WC_W-1:0]                   win_cnt;
  logic                                c1_q, c2_q, c3_q;
  logic                                accept, run, mism;
  logic   [NUM_LANES-1:0]              lane_inc;
  logic   [NUM_LANES-1:0][CNT_W-1:0]   lane_cnt;

  // Input stage: all accounting works on the one-cycle-old values.
  always_ff @(posedge clk) begin
    if (rst) {c1_q, c2_q, c3_q} <= '0;
    else     {c1_q, c2_q, c3_q} <= {c1, c2, c3};
  end

  assign mism = !((c1_q == c2_q) && (c2_q == c3_q));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state and outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    run       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        run  = 1'b1;
        // win_cnt counts RUN cycles already completed, so the last one is WIN_LEN-1
        if (win_cnt == WC_W'(WIN_LEN - 1) || (EARLY_STOP && mism))
          state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window length counter
  always_ff @(posedge clk) begin
    if (rst)         win_cnt <= '0;
    else if (accept) win_cnt <= '0;
    else if (run)    win_cnt <= win_cnt + 1'b1;
  end

  // Sticky error; a new window does not clear it
  always_ff @(posedge clk) begin
    if (rst)              err <= 1'b0;
    else if (run && mism) err <= 1'b1;
  end

  assign lane_inc = {mism, c3_q, c2_q, c1_q};

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      tri_out_monitor_lane #(.CNT_W(CNT_W)) u_lane (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (run),
        .inc (lane_inc[g]),
        .cnt (lane_cnt[g])
      );
    end
  endgenerate

  assign ones_c1      = lane_cnt[0];
  assign ones_c2      = lane_cnt[1];
  assign ones_c3      = lane_cnt[2];
  assign mismatch_cnt = lane_cnt[3];

endmodule
